// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: RAM handshake states, arbiter FSM states and index-width helper
package cpu_types_pkg;
  typedef enum logic [1:0] {FREE, BUSY, ACCESS, ERROR} ramstate_t;
  typedef enum logic {IDLE, GRANT} arb_state_t;
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/multicore_ram_arbiter_rr_pick.sv
// rr_pick: rotating-priority winner search starting just after i_last
module rr_pick #(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_last,
  output logic [IW-1:0] o_idx,
  output logic          o_valid
);
  int w_best, w_dist;
  // smallest rotational distance past i_last wins
  always_comb begin
    o_idx  = '0;
    w_best = N;
    w_dist = 0;
    for (int j = 0; j < N; j++) begin
      w_dist = (j + N - 1 - int'(i_last)) % N;
      if (i_req[j] && w_dist < w_best) begin
        w_best = w_dist;
        o_idx  = IW'(j);
      end
    end
  end
  assign o_valid = |i_req;
endmodule

// File: rtl/multicore_ram_arbiter.sv
// multicore_ram_arbiter: round-robin arbiter of cache channels onto one RAM port
module multicore_ram_arbiter
  import cpu_types_pkg::*;
#(
  parameter int NCORES = 2,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int WPRIO  = 1
) (
  input  logic                           CLK,
  input  logic                           RST,
  input  logic [NCORES-1:0]              req_ren,
  input  logic [NCORES-1:0]              req_wen,
  input  logic [NCORES-1:0][ADDR_W-1:0]  req_addr,
  input  logic [NCORES-1:0][DATA_W-1:0]  req_store,
  output logic [NCORES-1:0]              resp_wait,
  output logic [DATA_W-1:0]              resp_load,
  output logic [ADDR_W-1:0]              ramaddr,
  output logic [DATA_W-1:0]              ramstore,
  output logic                           ramREN,
  output logic                           ramWEN,
  input  logic [DATA_W-1:0]              ramload,
  input  ramstate_t                      ramstate,
  input  logic [NCORES-1:0]              flushed,
  output logic                           halt,
  output logic                           err
);
  localparam int IW = idx_w(NCORES);
  arb_state_t r_state, w_next;
  logic [IW-1:0] r_gnt, r_last, w_pick;
  logic [NCORES-1:0] w_cand;
  logic w_pick_v, w_g_ren, w_g_wen, w_active, w_done, w_fail, r_halt, r_err;
  // with write priority, readers only compete when nobody writes
  assign w_cand = (WPRIO != 0 && |req_wen) ? req_wen : (req_ren | req_wen);
  rr_pick #(.N(NCORES), .IW(IW)) u_pick (
    .i_req  (w_cand),
    .i_last (r_last),
    .o_idx  (w_pick),
    .o_valid(w_pick_v)
  );
  assign w_g_ren  = req_ren[r_gnt];
  assign w_g_wen  = req_wen[r_gnt];
  assign w_active = !RST && r_state == GRANT && (w_g_ren | w_g_wen);
  assign w_done   = w_active && ramstate == ACCESS;
  assign w_fail   = w_active && ramstate == ERROR;
  always_ff @(posedge CLK) begin
    if (RST) r_state <= IDLE;
    else     r_state <= w_next;
  end
  always_comb begin
    w_next = (r_state == IDLE) ? (w_pick_v ? GRANT : IDLE)
           : ((!(w_g_ren | w_g_wen) || w_done || w_fail) ? IDLE : GRANT);
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_gnt  <= '0;
      r_last <= IW'(NCORES - 1);
      r_halt <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      if (r_state == IDLE && w_pick_v) r_gnt <= w_pick;
      if (w_done || w_fail) r_last <= r_gnt;
      r_halt <= &flushed;
      r_err  <= w_fail;
    end
  end
  always_comb begin
    resp_wait = '1;
    if (w_done) resp_wait[r_gnt] = 1'b0;
    ramREN    = w_active && !w_g_wen;
    ramWEN    = w_active && w_g_wen;
    ramaddr   = w_active ? req_addr[r_gnt] : '0;
    ramstore  = w_active ? req_store[r_gnt] : '0;
    resp_load = (w_done && !w_g_wen) ? ramload : '0;
  end
  assign halt = r_halt;
  assign err  = r_err;
endmodule
